gesture_cmd_receiver: RTL and testbench
=======================================

# gesture_cmd_receiver

Receives gesture commands from the wireless link module as 8N1 UART bytes, validates each frame and produces the 4-bit `cmd_nibble` that drives the motor controller: speed in [3:2], steer in [1:0]. A watchdog forces a stop command when the link goes silent. The block sits between the UART RX pin and the motor controller's `cmd_nibble` input.

## Interface
- `CLK_HZ`, default 125000000: system clock frequency in Hz.
- `BAUD`, default 9600: UART bit rate.
- `TIMEOUT_MS`, default 500: watchdog silence limit in ms.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `cmd_nibble`  out  4  registered command: [3:2] speed (00 stop, 01 normal, 10 fast), [1:0] steer (00 straight, 10 left, 01 right).
- `cmd_valid`  out  1  one-cycle pulse when `cmd_nibble` is loaded from an accepted frame.
- `frame_err`  out  1  one-cycle pulse when a byte is rejected.
- `link_ok`  out  1  high while accepted frames arrive within the timeout.

## Operation
- **Input sync:** `uart_rx` passes through a 2-FF synchronizer. Both FFs reset to 1.
- **Bit period:** CLKS_PER_BIT = CLK_HZ/BAUD, integer truncation (13020 at defaults).
- **RX FSM:**
  - IDLE: leave on a synchronized 1→0 transition only.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. Sample 1 means a glitch: return to IDLE with no pulse. Sample 0 goes to DATA.
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. Sample 1 means the byte is done. Sample 0 pulses `frame_err`, discards the byte and returns to IDLE.
  - Because IDLE needs a 1→0 edge, a held-low line (break) does not retrigger.
- **Frame format:** one byte, [7:4] = header 4'hA, [3:0] = command.
- **Acceptance:** header == 4'hA, speed != 2'b11 and steer != 2'b11.
  - Accepted: `cmd_nibble` ← byte[3:0], `cmd_valid` pulses, `link_ok` ← 1, watchdog cleared.
  - Any other byte: `frame_err` pulses and `cmd_nibble` holds its value.
- **Watchdog:**
  - 32-bit cycle counter. TIMEOUT_CYCLES = (CLK_HZ/1000)*TIMEOUT_MS.
  - Counter increments every cycle and clears on each accepted frame.
  - On reaching TIMEOUT_CYCLES-1: `cmd_nibble` ← 4'h0, `link_ok` ← 0, and the counter saturates. No `cmd_valid` pulse on timeout.
  - If an accepted frame and the timeout fall in the same cycle, the accepted frame wins.
- `cmd_valid` and `frame_err` are never high in the same cycle.

## Timing
- **Reset values:** `cmd_nibble`=0, `cmd_valid`=0, `frame_err`=0, `link_ok`=0, FSM=IDLE, counters=0.
- Reset asserted mid-byte aborts the byte with no pulse. Reception restarts at the next falling edge after release.
- **Latency:** `cmd_nibble`, `cmd_valid` and `link_ok` update one cycle after the stop-bit sample cycle. The stop-bit sample is about 9.5 bit periods plus 2 sync cycles after the start-bit falling edge at the pin.
- Consecutive frames with zero gap between stop bit and next start bit are received without loss.
- All outputs are registered. No combinational path from `uart_rx` to any output.

## Configuration
- **`CMD_WATCHDOG_EN` defined:** the watchdog is present as described above.
- **`CMD_WATCHDOG_EN` undefined:**
  - No counter is built.
  - `link_ok` rises on the first accepted frame and stays high until reset.
  - `cmd_nibble` holds the last accepted command indefinitely.

## Structure
- **Package `gesture_cmd_pkg`:**
  - Header constant 4'hA.
  - Speed encodings: STOP, NORMAL, FAST.
  - Steer encodings: STRAIGHT, LEFT, RIGHT.
  - RX FSM state enum: IDLE, START, DATA, STOP.
- **Sub-module `uart_rx_8n1`:** synchronizer, bit timer and RX FSM. Outputs `byte_data[7:0]`, `byte_done` pulse and `stop_err` pulse.
- **Top level:** frame acceptance, output registers and watchdog.

## Test plan
Bench parameters: CLK_HZ=1000000, BAUD=100000 (10 clk/bit), TIMEOUT_MS=1 (1000 cycles), `CMD_WATCHDOG_EN` defined.
1. Send 0xA4 → `cmd_nibble`=4'h4, exactly one `cmd_valid` pulse, `link_ok`=1, `frame_err` stays 0.
2. After 0xA4, send 0x54, 0xAC and 0xA3 → three `frame_err` pulses, `cmd_nibble` stays 4'h4, no `cmd_valid`.
3. Send 0xA6 with the stop bit driven 0 → one `frame_err` pulse, `cmd_nibble` unchanged. Then send 0xA5 → `cmd_nibble`=4'h5.
4. Send 0xA9, then hold the line idle for 1000 cycles → `cmd_nibble`=0, `link_ok`=0. Then send 0xA8 → `cmd_nibble`=4'h8, `link_ok`=1.
5. Drive `uart_rx` low for 3 cycles → no pulses, FSM back in IDLE. Send back-to-back 0xA4, 0xA6 with no gap → two `cmd_valid` pulses, final `cmd_nibble`=4'h6.
6. Assert `reset_n` low during bit 4 of 0xA5 → all outputs 0. After release, send 0xA1 → `cmd_nibble`=4'h1.

Source files
------------

// File: rtl/gesture_cmd_pkg.sv
// Shared constants, command encodings and RX state type for the gesture command receiver.
package gesture_cmd_pkg;

    localparam logic [3:0] FRAME_HEADER = 4'hA;

    typedef enum logic [1:0] {
        SPEED_STOP   = 2'b00,
        SPEED_NORMAL = 2'b01,
        SPEED_FAST   = 2'b10
    } speed_e;

    typedef enum logic [1:0] {
        STEER_STRAIGHT = 2'b00,
        STEER_RIGHT    = 2'b01,
        STEER_LEFT     = 2'b10
    } steer_e;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // A frame carries a command only with the right header and legal speed/steer codes.
    function automatic logic frame_ok(input logic [7:0] frame);
        logic hdr_ok;
        logic speed_ok;
        logic steer_ok;
        hdr_ok   = (frame[7:4] == FRAME_HEADER);
        speed_ok = (frame[3:2] == SPEED_STOP) || (frame[3:2] == SPEED_NORMAL) ||
                   (frame[3:2] == SPEED_FAST);
        steer_ok = (frame[1:0] == STEER_STRAIGHT) || (frame[1:0] == STEER_RIGHT) ||
                   (frame[1:0] == STEER_LEFT);
        return hdr_ok && speed_ok && steer_ok;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchronizer, bit timer and RX FSM with
// single-cycle byte_done / stop_err strobes on the stop-bit sample cycle.
module uart_rx_8n1
    import gesture_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 13020
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;

    // rx_prev tracks the line so IDLE only leaves on a real 1->0 edge, never on a held break.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_err  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    byte_done = rx_sync;
                    stop_err  = !rx_sync;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/gesture_cmd_receiver.sv
// Validates received command frames and drives the registered motor command nibble.
// Define CMD_WATCHDOG_EN to build the link-silence watchdog that forces a stop command.
module gesture_cmd_receiver
    import gesture_cmd_pkg::*;
#(
    parameter int CLK_HZ     = 125000000,
    parameter int BAUD       = 9600,
    parameter int TIMEOUT_MS = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [3:0] cmd_nibble,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       link_ok
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [7:0] byte_data;
    logic       byte_done;
    logic       stop_err;
    logic       accept;
    logic       reject;
    logic       timeout;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .uart_rx  (uart_rx),
        .byte_data(byte_data),
        .byte_done(byte_done),
        .stop_err (stop_err)
    );

    assign accept = byte_done && frame_ok(byte_data);
    assign reject = stop_err || (byte_done && !frame_ok(byte_data));

`ifdef CMD_WATCHDOG_EN
    localparam logic [31:0] TIMEOUT_CYCLES = 32'((CLK_HZ / 1000) * TIMEOUT_MS);

    logic [31:0] wd_cnt_q;

    assign timeout = (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);

    // Counter parks at the limit so the forced stop persists until a frame is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
        end else if (accept) begin
            wd_cnt_q <= '0;
        end else if (!timeout) begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // An accepted frame takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_nibble <= 4'h0;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
            link_ok    <= 1'b0;
        end else begin
            cmd_valid <= accept;
            frame_err <= reject;
            if (accept) begin
                cmd_nibble <= byte_data[3:0];
                link_ok    <= 1'b1;
            end else if (timeout) begin
                cmd_nibble <= {SPEED_STOP, STEER_STRAIGHT};
                link_ok    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gesture_cmd_receiver.sv
// Scoreboard bench for gesture_cmd_receiver at 10 clocks per bit and a 1000-cycle watchdog.
module tb_gesture_cmd_receiver;

    localparam int CLK_HZ      = 1000000;
    localparam int BAUD        = 100000;
    localparam int TIMEOUT_MS  = 1;
    localparam int CPB         = CLK_HZ / BAUD;

    logic       clk;
    logic       reset_n;
    logic       uart_rx;
    logic [3:0] cmd_nibble;
    logic       cmd_valid;
    logic       frame_err;
    logic       link_ok;

    int         check_count = 0;
    int         err_count   = 0;
    int         valid_cnt   = 0;
    int         ferr_cnt    = 0;
    int         valid_base;
    int         ferr_base;
    logic [3:0] sb_q[$];

    gesture_cmd_receiver #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_rx   (uart_rx),
        .cmd_nibble(cmd_nibble),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .link_ok   (link_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference acceptance rule, written independently of the design package.
    function automatic bit modelAccept(input logic [7:0] b);
        return (b[7:4] == 4'hA) && (b[3:2] != 2'b11) && (b[1:0] != 2'b11);
    endfunction

    // Drives one 8N1 frame at negedges; expected nibble goes into the scoreboard.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int idle_cycles);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        if (stop_bit && modelAccept(b)) sb_q.push_back(b[3:0]);
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (idle_cycles) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmd_valid) begin
            valid_cnt++;
            checkOutput("valid_link_ok", int'(link_ok), 1);
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                checkOutput("cmd_nibble_sb", int'(cmd_nibble), int'(sb_q.pop_front()));
            end
        end
        if (frame_err) begin
            ferr_cnt++;
            checkOutput("err_not_with_valid", int'(cmd_valid), 0);
        end
    end

    task automatic markCounts();
        valid_base = valid_cnt;
        ferr_base  = ferr_cnt;
    endtask

    initial begin
        logic [9:0] bits;
        uart_rx = 1'b1;
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_cmd", int'(cmd_nibble), 0);
        checkOutput("rst_valid", int'(cmd_valid), 0);
        checkOutput("rst_ferr", int'(frame_err), 0);
        checkOutput("rst_link", int'(link_ok), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] test 1: good frame");
        markCounts();
        applyStimulus(8'hA4, 1'b1, 20);
        checkOutput("t1_valid_pulses", valid_cnt - valid_base, 1);
        checkOutput("t1_ferr_pulses", ferr_cnt - ferr_base, 0);
        checkOutput("t1_cmd", int'(cmd_nibble), 4'h4);
        checkOutput("t1_link", int'(link_ok), 1);

        $display("[TB] test 2: rejected frames");
        markCounts();
        applyStimulus(8'h54, 1'b1, 5);
        applyStimulus(8'hAC, 1'b1, 5);
        applyStimulus(8'hA3, 1'b1, 5);
        checkOutput("t2_ferr_pulses", ferr_cnt - ferr_base, 3);
        checkOutput("t2_valid_pulses", valid_cnt - valid_base, 0);
        checkOutput("t2_cmd", int'(cmd_nibble), 4'h4);

        $display("[TB] test 3: bad stop bit");
        markCounts();
        applyStimulus(8'hA6, 1'b0, 20);
        checkOutput("t3_ferr_pulses", ferr_cnt - ferr_base, 1);
        checkOutput("t3_cmd_hold", int'(cmd_nibble), 4'h4);
        applyStimulus(8'hA5, 1'b1, 20);
        checkOutput("t3_cmd", int'(cmd_nibble), 4'h5);
        checkOutput("t3_valid_pulses", valid_cnt - valid_base, 1);

        $display("[TB] test 4: watchdog");
        applyStimulus(8'hA9, 1'b1, 20);
        checkOutput("t4_cmd", int'(cmd_nibble), 4'h9);
        markCounts();
        repeat (900) @(negedge clk);
        checkOutput("t4_link_before", int'(link_ok), 1);
        repeat (100) @(negedge clk);
`ifdef CMD_WATCHDOG_EN
        checkOutput("t4_cmd_timeout", int'(cmd_nibble), 0);
        checkOutput("t4_link_timeout", int'(link_ok), 0);
`else
        checkOutput("t4_cmd_hold", int'(cmd_nibble), 4'h9);
        checkOutput("t4_link_hold", int'(link_ok), 1);
`endif
        checkOutput("t4_no_valid", valid_cnt - valid_base, 0);
        applyStimulus(8'hA8, 1'b1, 20);
        checkOutput("t4_cmd_after", int'(cmd_nibble), 4'h8);
        checkOutput("t4_link_after", int'(link_ok), 1);

        $display("[TB] test 5: glitch and back-to-back");
        markCounts();
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("t5_glitch_valid", valid_cnt - valid_base, 0);
        checkOutput("t5_glitch_ferr", ferr_cnt - ferr_base, 0);
        applyStimulus(8'hA4, 1'b1, 0);
        applyStimulus(8'hA6, 1'b1, 20);
        checkOutput("t5_valid_pulses", valid_cnt - valid_base, 2);
        checkOutput("t5_cmd", int'(cmd_nibble), 4'h6);

        $display("[TB] test 6: reset mid-byte");
        markCounts();
        bits = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 5; i++) begin
            uart_rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = bits[5];
        repeat (CPB / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6_rst_cmd", int'(cmd_nibble), 0);
        checkOutput("t6_rst_link", int'(link_ok), 0);
        checkOutput("t6_rst_valid", int'(cmd_valid), 0);
        checkOutput("t6_rst_ferr", int'(frame_err), 0);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t6_no_pulses", (valid_cnt - valid_base) + (ferr_cnt - ferr_base), 0);
        applyStimulus(8'hA1, 1'b1, 20);
        checkOutput("t6_cmd", int'(cmd_nibble), 4'h1);
        checkOutput("t6_link", int'(link_ok), 1);

        checkOutput("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
